// File: rtl/mu0_core.sv
// Multicycle MU0 core: FETCH/EXECUTE control plus ACC/PC/IR datapath, bus master for a 16-bit memory.
// Optional build macro MU0_TRAP_EN: opcodes 8-F trap to HALT and raise illegal_op instead of executing as NOP.
module mu0_core #(
   parameter logic [11:0] RESET_PC = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [15:0] mem_rdata,
   output logic        memRq,
   output logic        readNotWrite,
   output logic [15:0] addr,
   output logic [15:0] mem_wdata,
   output logic [15:0] acc,
   output logic [11:0] pc,
   output logic        halted
`ifdef MU0_TRAP_EN
   ,
   output logic        illegal_op
`endif
);

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 12;
   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_LDA = 4'h0;
   localparam logic [OPW-1:0] OP_STA = 4'h1;
   localparam logic [OPW-1:0] OP_ADD = 4'h2;
   localparam logic [OPW-1:0] OP_SUB = 4'h3;
   localparam logic [OPW-1:0] OP_JMP = 4'h4;
   localparam logic [OPW-1:0] OP_JGE = 4'h5;
   localparam logic [OPW-1:0] OP_JNE = 4'h6;
   localparam logic [OPW-1:0] OP_STP = 4'h7;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALT    = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [DW-1:0]  ir;
   logic [OPW-1:0] op;
   logic [AW-1:0]  s;
   logic           op_illegal;

   assign op         = ir[15:12];
   assign s          = ir[11:0];
   assign op_illegal = op[3];
   assign mem_wdata  = acc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   // Next-state logic; an instruction once fetched always completes regardless of run
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (run) state_nxt = EXECUTE;
         EXECUTE: begin
            if (op == OP_STP) state_nxt = HALT;
`ifdef MU0_TRAP_EN
            else if (op_illegal) state_nxt = HALT;
`endif
            else state_nxt = FETCH;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // Bus decode; gated by rst_n so the request drops the instant reset asserts
   always_comb begin
      memRq        = 1'b0;
      readNotWrite = 1'b1;
      addr         = '0;
      if (rst_n) begin
         case (state)
            FETCH: begin
               if (run) begin
                  memRq = 1'b1;
                  addr  = DW'(pc);
               end
            end
            EXECUTE: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     memRq = 1'b1;
                     addr  = DW'(s);
                  end
                  OP_STA: begin
                     memRq        = 1'b1;
                     readNotWrite = 1'b0;
                     addr         = DW'(s);
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Datapath registers; a taken jump in EXECUTE overrides the FETCH increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         acc    <= '0;
         ir     <= '0;
         halted <= 1'b0;
`ifdef MU0_TRAP_EN
         illegal_op <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (run) begin
                  ir <= mem_rdata;
                  pc <= pc + AW'(1);
               end
            end
            EXECUTE: begin
               case (op)
                  OP_LDA: acc <= mem_rdata;
                  OP_ADD: acc <= acc + mem_rdata;
                  OP_SUB: acc <= acc - mem_rdata;
                  OP_JMP: pc  <= s;
                  OP_JGE: if (!acc[DW-1]) pc <= s;
                  OP_JNE: if (acc != '0) pc <= s;
                  OP_STP: halted <= 1'b1;
                  default: begin
`ifdef MU0_TRAP_EN
                     if (op_illegal) begin
                        illegal_op <= 1'b1;
                        halted     <= 1'b1;
                     end
`endif
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mu0_core.sv
// Directed bench for mu0_core with a behavioural single-port memory model.
module tb_mu0_core;

   localparam int unsigned MEM_WORDS = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [15:0] mem_rdata;
   logic        memRq;
   logic        readNotWrite;
   logic [15:0] addr;
   logic [15:0] mem_wdata;
   logic [15:0] acc;
   logic [11:0] pc;
   logic        halted;
`ifdef MU0_TRAP_EN
   logic        illegal_op;
`endif

   mu0_core #(.RESET_PC(12'h000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .mem_rdata    (mem_rdata),
      .memRq        (memRq),
      .readNotWrite (readNotWrite),
      .addr         (addr),
      .mem_wdata    (mem_wdata),
      .acc          (acc),
      .pc           (pc),
      .halted       (halted)
`ifdef MU0_TRAP_EN
      ,
      .illegal_op   (illegal_op)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the edge, bench preload/clear port
   logic [15:0] mem [MEM_WORDS];
   logic        mem_clr = 1'b0;
   logic        ld_en = 1'b0;
   logic [11:0] ld_addr = '0;
   logic [15:0] ld_data = '0;

   assign mem_rdata = (memRq && readNotWrite) ? mem[addr[11:0]] : 16'hbfbf;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      end else if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (memRq && !readNotWrite) begin
         mem[addr[11:0]] <= mem_wdata;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic begin_test();
      rst_n   = 1'b0;
      run     = 1'b0;
      mem_clr = 1'b1;
      @(posedge clk); #1;
      mem_clr = 1'b0;
   endtask

   task automatic load(input logic [11:0] a, input logic [15:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      @(posedge clk); #1;
      ld_en   = 1'b0;
   endtask

   task automatic release_rst(input logic r);
      run = r;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;

      // Reset state with run high: bus must stay idle while reset is held
      begin_test();
      run = 1'b1;
      #1;
      check("rst_memRq", 32'(memRq), 32'd0);
      check("rst_rnw", 32'(readNotWrite), 32'd1);
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_wdata", 32'(mem_wdata), 32'h0);
      check("rst_pc", 32'(pc), 32'h000);
      check("rst_acc", 32'(acc), 32'h0);
      check("rst_halted", 32'(halted), 32'd0);

      // Add and store: LDA 10, ADD 11, STA 12, STP -> halts on the 8th edge
      begin_test();
      load(12'h000, 16'h0010);
      load(12'h001, 16'h2011);
      load(12'h002, 16'h1012);
      load(12'h003, 16'h7000);
      load(12'h010, 16'd5);
      load(12'h011, 16'd7);
      release_rst(1'b1);
      edges(1);
      check("as_fetch_pc", 32'(pc), 32'h001);
      edges(6);
      check("as_halted_e7", 32'(halted), 32'd0);
      edges(1);
      check("as_halted_e8", 32'(halted), 32'd1);
      check("as_acc", 32'(acc), 32'd12);
      check("as_pc", 32'(pc), 32'h004);
      check("as_mem12", 32'(mem[12'h012]), 32'd12);
      edges(3);
      check("as_hold_pc", 32'(pc), 32'h004);
      check("as_hold_memRq", 32'(memRq), 32'd0);

      // Countdown: LDA cnt; SUB one; STA cnt; JNE 1; STP.
      // LDA + 3 x (SUB,STA,JNE) + STP = 11 instructions = 22 edges
      begin_test();
      load(12'h000, 16'h0020);
      load(12'h001, 16'h3021);
      load(12'h002, 16'h1020);
      load(12'h003, 16'h6001);
      load(12'h004, 16'h7000);
      load(12'h020, 16'd3);
      load(12'h021, 16'd1);
      release_rst(1'b1);
      cyc = 0;
      while (!halted && cyc < 40) begin
         edges(1);
         cyc++;
      end
      check("cd_cycles", 32'(cyc), 32'd22);
      check("cd_cnt", 32'(mem[12'h020]), 32'd0);
      check("cd_pc", 32'(pc), 32'h005);
      check("cd_halted", 32'(halted), 32'd1);

      // JGE with negative acc: not taken
      begin_test();
      load(12'h000, 16'h0030);
      load(12'h001, 16'h5008);
      load(12'h030, 16'h8000);
      release_rst(1'b1);
      edges(4);
      check("jge_nt_acc", 32'(acc), 32'h8000);
      check("jge_nt_pc", 32'(pc), 32'h002);

      // JGE with zero acc: taken
      begin_test();
      load(12'h000, 16'h0030);
      load(12'h001, 16'h5008);
      load(12'h008, 16'h7000);
      load(12'h030, 16'h0000);
      release_rst(1'b1);
      edges(4);
      check("jge_t_pc", 32'(pc), 32'h008);
      edges(2);
      check("jge_t_halt", 32'(halted), 32'd1);
      check("jge_t_halt_pc", 32'(pc), 32'h009);

      // Run gating: idle 5 cycles, then drop run during EXECUTE of STA
      begin_test();
      load(12'h000, 16'h0010);
      load(12'h001, 16'h1020);
      load(12'h010, 16'h1234);
      load(12'h020, 16'hdead);
      release_rst(1'b0);
      for (int i = 0; i < 5; i++) begin
         edges(1);
         check("gate_memRq", 32'(memRq), 32'd0);
         check("gate_pc", 32'(pc), 32'h000);
      end
      run = 1'b1;
      edges(3);
      check("gate_sta_memRq", 32'(memRq), 32'd1);
      check("gate_sta_rnw", 32'(readNotWrite), 32'd0);
      check("gate_sta_addr", 32'(addr), 32'h0020);
      check("gate_sta_wdata", 32'(mem_wdata), 32'h1234);
      run = 1'b0;
      edges(1);
      check("gate_sta_mem", 32'(mem[12'h020]), 32'h1234);
      edges(3);
      check("gate_stall_pc", 32'(pc), 32'h002);
      check("gate_stall_memRq", 32'(memRq), 32'd0);
      check("gate_stall_halted", 32'(halted), 32'd0);

      // Reset asserted during EXECUTE of STA, ahead of the edge
      begin_test();
      load(12'h000, 16'h0010);
      load(12'h001, 16'h1020);
      load(12'h010, 16'h1234);
      load(12'h020, 16'hdead);
      release_rst(1'b1);
      edges(3);
      check("mrst_pre_memRq", 32'(memRq), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_memRq", 32'(memRq), 32'd0);
      check("mrst_rnw", 32'(readNotWrite), 32'd1);
      check("mrst_addr", 32'(addr), 32'h0);
      check("mrst_pc", 32'(pc), 32'h000);
      check("mrst_acc", 32'(acc), 32'h0);
      edges(1);
      check("mrst_mem", 32'(mem[12'h020]), 32'hdead);

      // Illegal opcode at FFE followed by LDA at FFF (PC wrap)
      begin_test();
      load(12'h000, 16'h4ffe);
      load(12'hffe, 16'h9000);
      load(12'hfff, 16'h0010);
      load(12'h010, 16'h0055);
      release_rst(1'b1);
      edges(3);
      check("ill_exec_pc", 32'(pc), 32'hfff);
      check("ill_exec_memRq", 32'(memRq), 32'd0);
      check("ill_exec_addr", 32'(addr), 32'h0);
      edges(1);
`ifdef MU0_TRAP_EN
      check("ill_trap_flag", 32'(illegal_op), 32'd1);
      check("ill_trap_halted", 32'(halted), 32'd1);
      check("ill_trap_pc", 32'(pc), 32'hfff);
      edges(2);
      check("ill_trap_hold_pc", 32'(pc), 32'hfff);
`else
      check("ill_nop_halted", 32'(halted), 32'd0);
      check("ill_nop_pc", 32'(pc), 32'hfff);
      check("ill_nop_acc", 32'(acc), 32'h0);
      check("ill_nop_fetch_addr", 32'(addr), 32'h0fff);
      edges(1);
      check("wrap_pc", 32'(pc), 32'h000);
      edges(1);
      check("wrap_acc", 32'(acc), 32'h0055);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
